// File: rtl/turn_sched.sv
`default_nettype none
// ============================================================================
// Module      : turn_sched
// Description : Two-player turn scheduler. Owns the shared button pad and
//               turns held buttons into rate-limited single-cycle step
//               strobes for the active player's position/aim registers.
//               Sequences the move window, the fire phase and the hand-off
//               between the two players.
// Ports       : clk, reset (async, active-high)
//               btn_left/btn_right/btn_aim_l/btn_aim_r/btn_fire - level buttons
//               shot_done     - projectile finished (1-cycle pulse)
//               p0_*/p1_*     - per-player step strobes (x and aim pairs)
//               active_player - player whose turn it is
//               fire_start    - 1-cycle pulse on the first FIRE cycle
//               state         - 00 IDLE, 01 MOVE, 10 FIRE, 11 SWITCH
//               time_left     - remaining move-window cycles
// Revision    : 1.0 - initial release
// ============================================================================
module turn_sched #(
    parameter int REPEAT_CYCLES = 8,
    parameter int TURN_CYCLES   = 200,
    parameter int FIRE_CYCLES   = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic                               btn_aim_l,
    input  logic                               btn_aim_r,
    input  logic                               btn_fire,
    input  logic                               shot_done,
    output logic                               p0_left_x,
    output logic                               p0_right_x,
    output logic                               p0_left_aim,
    output logic                               p0_right_aim,
    output logic                               p1_left_x,
    output logic                               p1_right_x,
    output logic                               p1_left_aim,
    output logic                               p1_right_aim,
    output logic                               active_player,
    output logic                               fire_start,
    output logic [1:0]                         state,
    output logic [$clog2(TURN_CYCLES+1)-1:0]   time_left
);

    localparam int TL_W = $clog2(TURN_CYCLES + 1);
    localparam int RC_W = $clog2(REPEAT_CYCLES + 1);
    localparam int FC_W = $clog2(FIRE_CYCLES + 1);

    localparam logic [TL_W-1:0] c_turn_load = TL_W'(TURN_CYCLES);
    localparam logic [RC_W-1:0] c_rep_load  = RC_W'(REPEAT_CYCLES);
    localparam logic [FC_W-1:0] c_fire_load = FC_W'(FIRE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE   = 2'b01,
        ST_FIRE   = 2'b10,
        ST_SWITCH = 2'b11
    } state_t;

    // Button vector order: 0 left, 1 right, 2 aim_l, 3 aim_r, 4 fire
    logic [4:0]      w_btn;
    logic [4:0]      w_rise;
    logic [4:0]      r_hist;

    state_t          r_state,      w_state_next;
    logic            r_active,     w_active_next;
    logic [TL_W-1:0] r_time_left,  w_time_left_next;
    logic [FC_W-1:0] r_fire_cnt,   w_fire_cnt_next;
    logic            r_fire_start, w_fire_start_next;
    logic [RC_W-1:0] r_mv_cnt,     w_mv_cnt_next;
    logic [RC_W-1:0] r_aim_cnt,    w_aim_cnt_next;
    logic [3:0]      r_p0_strb,    w_p0_strb_next;
    logic [3:0]      r_p1_strb,    w_p1_strb_next;

    logic            w_run;
    logic [RC_W+1:0] w_mv_step;
    logic [RC_W+1:0] w_aim_step;
    logic [3:0]      w_strb;

    assign w_btn  = {btn_fire, btn_aim_r, btn_aim_l, btn_right, btn_left};
    assign w_rise = w_btn & ~r_hist;

    // One direction pair. Returns {strobe_a, strobe_b, next_count}.
    // A press counts as fresh when the button just rose or when the opposing
    // button was released while this one stayed held.
    function automatic logic [RC_W+1:0] pair_step(
        input logic            a,
        input logic            b,
        input logic            prev_a,
        input logic            prev_b,
        input logic [RC_W-1:0] cnt
    );
        logic            sa;
        logic            sb;
        logic [RC_W-1:0] nc;
        sa = 1'b0;
        sb = 1'b0;
        nc = '0;
        if (a && !b) begin
            if (!prev_a || prev_b) begin
                sa = 1'b1;
                nc = c_rep_load;
            end else if (cnt == RC_W'(1)) begin
                sa = 1'b1;
                nc = c_rep_load;
            end else if (cnt != '0) begin
                nc = cnt - RC_W'(1);
            end
        end else if (b && !a) begin
            if (!prev_b || prev_a) begin
                sb = 1'b1;
                nc = c_rep_load;
            end else if (cnt == RC_W'(1)) begin
                sb = 1'b1;
                nc = c_rep_load;
            end else if (cnt != '0) begin
                nc = cnt - RC_W'(1);
            end
        end
        return {sa, sb, nc};
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_active_next     = r_active;
        w_time_left_next  = r_time_left;
        w_fire_cnt_next   = r_fire_cnt;
        w_fire_start_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_rise) begin
                    w_state_next     = ST_MOVE;
                    w_time_left_next = c_turn_load;
                end
            end
            ST_MOVE: begin
                w_time_left_next = (r_time_left != '0) ? r_time_left - TL_W'(1) : '0;
                // Fire takes priority over window expiry in the same cycle
                if (w_rise[4]) begin
                    w_state_next      = ST_FIRE;
                    w_fire_start_next = 1'b1;
                    w_fire_cnt_next   = c_fire_load;
                end else if (r_time_left <= TL_W'(1)) begin
                    w_state_next = ST_SWITCH;
                end
            end
            ST_FIRE: begin
                if (shot_done || (r_fire_cnt <= FC_W'(1))) begin
                    w_state_next = ST_SWITCH;
                end else begin
                    w_fire_cnt_next = r_fire_cnt - FC_W'(1);
                end
            end
            ST_SWITCH: begin
                w_state_next     = ST_MOVE;
                w_active_next    = ~r_active;
                w_time_left_next = c_turn_load;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Strobes only fire when MOVE continues into the next cycle, so no
        // strobe ever lands in a non-MOVE state and the IDLE start edge is
        // consumed without stepping.
        w_run      = (r_state == ST_MOVE) && (w_state_next == ST_MOVE);
        w_mv_step  = pair_step(btn_left, btn_right, r_hist[0], r_hist[1], r_mv_cnt);
        w_aim_step = pair_step(btn_aim_l, btn_aim_r, r_hist[2], r_hist[3], r_aim_cnt);

        if (w_run) begin
            w_strb         = {w_aim_step[RC_W], w_aim_step[RC_W+1],
                              w_mv_step[RC_W],  w_mv_step[RC_W+1]};
            w_mv_cnt_next  = w_mv_step[RC_W-1:0];
            w_aim_cnt_next = w_aim_step[RC_W-1:0];
        end else begin
            w_strb         = 4'b0000;
            w_mv_cnt_next  = '0;
            w_aim_cnt_next = '0;
        end

        w_p0_strb_next = r_active ? 4'b0000 : w_strb;
        w_p1_strb_next = r_active ? w_strb  : 4'b0000;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_active     <= 1'b0;
            r_time_left  <= '0;
            r_fire_cnt   <= '0;
            r_fire_start <= 1'b0;
            r_mv_cnt     <= '0;
            r_aim_cnt    <= '0;
            r_p0_strb    <= 4'b0000;
            r_p1_strb    <= 4'b0000;
            r_hist       <= 5'b00000;
        end else begin
            r_state      <= w_state_next;
            r_active     <= w_active_next;
            r_time_left  <= w_time_left_next;
            r_fire_cnt   <= w_fire_cnt_next;
            r_fire_start <= w_fire_start_next;
            r_mv_cnt     <= w_mv_cnt_next;
            r_aim_cnt    <= w_aim_cnt_next;
            r_p0_strb    <= w_p0_strb_next;
            r_p1_strb    <= w_p1_strb_next;
            r_hist       <= w_btn;
        end
    end

    assign {p0_right_aim, p0_left_aim, p0_right_x, p0_left_x} = r_p0_strb;
    assign {p1_right_aim, p1_left_aim, p1_right_x, p1_left_x} = r_p1_strb;
    assign active_player = r_active;
    assign fire_start    = r_fire_start;
    assign state         = r_state;
    assign time_left     = r_time_left;

endmodule
`default_nettype wire
